// File: rtl/mux_nt1_pipe_pkg.sv
// Shared definitions for the registered N-to-1 multiplexer.
//   clog2        : ceiling log2, used to size/qualify the select range check
//   ST_*         : skid buffer occupancy encodings
//   buf_state_t  : typed view of the occupancy register (2'd3 is unreachable)
package mux_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    BUF_EMPTY = ST_EMPTY,
    BUF_ONE   = ST_ONE,
    BUF_TWO   = ST_TWO,
    BUF_BAD   = 2'd3
  } buf_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nt1_pipe_if.sv
// Handshake/data bundle for mux_nt1_pipe.
//   I, s, s_lock, in_valid : upstream operands, select and valid
//   in_ready               : block can accept
//   o, out_valid, out_ready: downstream word and handshake
//   s_q, sel_err           : latched select and sticky out-of-range flag
// master = the side that drives operands and consumes results; slave = the mux.
interface mux_nt1_pipe_if #(
  parameter int WIDTH = 5,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
);
  logic [NUM*WIDTH-1:0] I;
  logic [SEL_W-1:0]     s;
  logic                 s_lock;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     o;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     s_q;
  logic                 sel_err;

  modport master (
    output I, s, s_lock, in_valid, out_ready,
    input  in_ready, o, out_valid, s_q, sel_err
  );

  modport slave (
    input  I, s, s_lock, in_valid, out_ready,
    output in_ready, o, out_valid, s_q, sel_err
  );
endinterface

// File: rtl/mux_nt1_pipe_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides.
//   clk, rst (sync, active-low)
//   push_valid/push_data/push_ready : upstream side
//   pop_valid/pop_data/pop_ready    : downstream side (pop_data = head register)
// push_ready and pop_valid decode the state register only, so there is no
// combinational path from pop_ready to push_ready.
//
//   state     | meaning
//   BUF_EMPTY | no word held
//   BUF_ONE   | word in head, skid free
//   BUF_TWO   | head and skid both full, upstream stalled
//   BUF_BAD   | unreachable, recovers to BUF_EMPTY
module mux_skid_buf
  import mux_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready
);

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push;
  logic             pop;

  assign push_ready = (state_q != BUF_TWO);
  assign pop_valid  = (state_q == BUF_ONE) || (state_q == BUF_TWO);
  assign pop_data   = head_q;

  assign push = push_valid & push_ready;
  assign pop  = pop_valid & pop_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          skid_d  = push_data;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      BUF_BAD: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/mux_nt1_pipe.sv
// Registered N-to-1 multiplexer with valid/ready handshake and 2-entry skid buffer.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : mux_nt1_pipe_if.slave (operands, select, handshakes, s_q, sel_err)
// Holds the select latch, the index decode with range check, the sticky
// sel_err flag, and feeds the captured word into the skid buffer.
module mux_nt1_pipe
  import mux_pkg::*;
#(
  parameter int          WIDTH   = 5,
  parameter int          NUM     = 4,
  parameter int          SEL_W   = 2,
  parameter int unsigned DEFAULT = 0
) (
  input logic           clk,
  input logic           rst,
  mux_nt1_pipe_if.slave bus
);

  // Out-of-range selects exist only when the select field can encode more
  // values than there are inputs; otherwise the comparator folds away.
  localparam bit SEL_CAN_OOR = (SEL_W > clog2(NUM)) || (NUM != (1 << clog2(NUM)));

  logic [SEL_W-1:0] s_q_q, s_q_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] es;
  logic [WIDTH-1:0] cap_word;
  logic             sel_oor;
  logic             accept;
  logic             in_ready_w;
  logic             out_valid_w;
  logic [WIDTH-1:0] o_w;

  assign es     = bus.s_lock ? s_q_q : bus.s;
  assign accept = bus.in_valid & in_ready_w;

  always_comb begin
    cap_word = WIDTH'(DEFAULT);
    sel_oor  = 1'b0;
    if (SEL_CAN_OOR && (int'(es) >= NUM)) sel_oor = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      if (int'(es) == k) cap_word = bus.I[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    s_q_d     = s_q_q;
    sel_err_d = sel_err_q;
    if (accept && !bus.s_lock) s_q_d = bus.s;
    if (accept && sel_oor)     sel_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      s_q_q     <= s_q_d;
      sel_err_q <= sel_err_d;
    end
  end

  mux_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_data  (cap_word),
    .push_ready (in_ready_w),
    .pop_valid  (out_valid_w),
    .pop_data   (o_w),
    .pop_ready  (bus.out_ready)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.o         = o_w;
  assign bus.s_q       = s_q_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nt1_pipe.sv
module tb_mux_nt1_pipe;
  localparam int W   = 5;
  localparam int N   = 4;
  localparam int SW  = 3;
  localparam logic [W-1:0] DEF = 5'h1F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_nt1_pipe_if #(.WIDTH(W), .NUM(N), .SEL_W(SW)) bus ();

  mux_nt1_pipe #(.WIDTH(W), .NUM(N), .SEL_W(SW), .DEFAULT(32'h1F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two words plus the select latch and
  // sticky error, advanced once per rising edge from the bench's own inputs.
  logic [W-1:0] mq[$];
  logic [SW-1:0] m_sq;
  logic m_err;
  bit   m_live = 0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_sq  = '0;
      m_err = 1'b0;
      m_live = 1;
    end else begin
      bit acc, pop;
      int es;
      logic [W-1:0] word;
      logic [N*W-1:0] iv;
      acc = bus.in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && bus.out_ready;
      es  = bus.s_lock ? int'(m_sq) : int'(bus.s);
      iv  = bus.I;
      word = (es < N) ? iv[es*W +: W] : DEF;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(word);
        if (!bus.s_lock) m_sq = bus.s;
        if (es >= N) m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("out_valid", bus.out_valid, (mq.size() > 0));
      check("in_ready", bus.in_ready, (mq.size() < 2));
      check("s_q", bus.s_q, m_sq);
      check("sel_err", bus.sel_err, m_err);
      if (mq.size() > 0) check("o", bus.o, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.I = '0; bus.s = '0; bus.s_lock = 0; bus.in_valid = 0; bus.out_ready = 0;

    // reset for two cycles
    rst = 0;
    step(); step();
    check("rst_o", bus.o, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_sel_err", bus.sel_err, 0);
    check("rst_s_q", bus.s_q, 0);
    rst = 1;

    // select sweep
    bus.I = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      bus.s = SW'(k); bus.in_valid = 1;
      step();
      check("sweep_o", bus.o, k + 1);
      check("sweep_valid", bus.out_valid, 1);
    end
    bus.in_valid = 0;
    step();
    check("sweep_drain", bus.out_valid, 0);

    // backpressure
    bus.out_ready = 0;
    bus.s = 3'd1; bus.in_valid = 1;
    step();
    check("bp_o1", bus.o, 2);
    check("bp_rdy1", bus.in_ready, 1);
    bus.s = 3'd2;
    step();
    check("bp_rdy2", bus.in_ready, 0);
    check("bp_o_held", bus.o, 2);
    bus.in_valid = 0;
    step();
    check("bp_o_stall", bus.o, 2);
    bus.out_ready = 1;
    step();
    check("bp_o3", bus.o, 3);
    check("bp_rdy_back", bus.in_ready, 1);
    step();
    check("bp_empty", bus.out_valid, 0);

    // lock
    bus.s = 3'd3; bus.s_lock = 0; bus.in_valid = 1;
    step();
    check("lock_o1", bus.o, 4);
    bus.s = 3'd0; bus.s_lock = 1;
    step();
    check("lock_o2", bus.o, 4);
    check("lock_sq", bus.s_q, 3);
    bus.in_valid = 0; bus.s_lock = 0;
    step();

    // out of range
    bus.s = 3'd6; bus.in_valid = 1;
    step();
    check("oor_o", bus.o, 5'h1F);
    check("oor_err", bus.sel_err, 1);
    bus.s = 3'd1;
    step();
    check("oor_o_next", bus.o, 2);
    check("oor_err_sticky", bus.sel_err, 1);
    bus.in_valid = 0;
    step();

    // reset with the buffer full
    bus.out_ready = 0; bus.in_valid = 1; bus.s = 3'd2;
    step(); step();
    check("mid_full", bus.in_ready, 0);
    bus.in_valid = 0;
    rst = 0;
    step();
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_in_ready", bus.in_ready, 1);
    check("mid_sel_err", bus.sel_err, 0);
    rst = 1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.I         = 20'($urandom);
      bus.s         = SW'($urandom_range(0, 7));
      bus.s_lock    = ($urandom_range(0, 3) == 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rst           = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
